// File: rtl/if_fetch_if.sv
// Instruction-SRAM channel: the fetch stage (master) issues req/addr, the SRAM (slave)
// answers with addr_ok on acceptance and data_ok/rdata in request order.
interface if_fetch_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  inst_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_data_ok,
    output inst_rdata
  );
endinterface

// File: rtl/if_fetch.sv
// MIPS instruction-fetch stage: one outstanding SRAM request, a one-entry result buffer,
// an output register towards decode, and branch redirect with a one-instruction delay slot.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  stall,
  input  logic [32:0] br_bus,
  if_fetch_if.master  sram,
  output logic [32:0] if_to_id_bus,
  output logic [31:0] if_inst,
  output logic        stallreq
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_FULL} state_e;

  state_e      state_q, state_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] fly_pc_q, fly_pc_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic        cancel_q, cancel_d;
  logic        redir_valid_q, redir_valid_d;
  logic [31:0] redir_addr_q, redir_addr_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_inst_q, out_inst_d;

  logic        consume;
  logic        br_take;
  logic [31:0] br_addr;
  logic        kill;
  logic        can_load;
  logic        data_live;
  logic        slot_is_req;
  logic        unused_stall;

  assign consume   = ~stall[1];
  assign br_take   = br_bus[32] & consume;
  assign br_addr   = br_bus[31:0];
  assign can_load  = ~out_valid_q | consume;
  assign data_live = (state_q == S_WAIT) & sram.inst_data_ok & ~cancel_q;
  // With the output register full, it is the delay slot and everything behind it is wrong-path.
  assign kill      = br_take & out_valid_q;
  // A cancelled in-flight request no longer counts, so req_pc itself becomes the delay slot.
  assign slot_is_req = ~out_valid_q &
                       ((state_q == S_REQ) | ((state_q == S_WAIT) & cancel_q));
  assign unused_stall = ^{stall[5:2], stall[0]};

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_inst_d  = out_inst_q;
    if (can_load) begin
      if ((state_q == S_FULL) && !kill) begin
        out_valid_d = 1'b1;
        out_pc_d    = buf_pc_q;
        out_inst_d  = buf_inst_q;
      end else if (data_live && !kill) begin
        out_valid_d = 1'b1;
        out_pc_d    = fly_pc_q;
        out_inst_d  = sram.inst_rdata;
      end else begin
        out_valid_d = 1'b0;
        out_pc_d    = '0;
        out_inst_d  = '0;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    req_pc_d      = req_pc_q;
    fly_pc_d      = fly_pc_q;
    buf_pc_d      = buf_pc_q;
    buf_inst_d    = buf_inst_q;
    cancel_d      = cancel_q;
    redir_valid_d = redir_valid_q;
    redir_addr_d  = redir_addr_q;

    case (state_q)
      S_REQ: begin
        if (sram.inst_addr_ok) begin
          state_d       = S_WAIT;
          fly_pc_d      = req_pc_q;
          req_pc_d      = redir_valid_q ? redir_addr_q : req_pc_q + 32'd4;
          redir_valid_d = 1'b0;
        end
      end
      S_WAIT: begin
        if (sram.inst_data_ok) begin
          if (cancel_q) begin
            cancel_d = 1'b0;
            state_d  = S_REQ;
          end else if (can_load) begin
            state_d = S_REQ;
          end else begin
            buf_pc_d   = fly_pc_q;
            buf_inst_d = sram.inst_rdata;
            state_d    = S_FULL;
          end
        end
      end
      S_FULL: begin
        if (can_load) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase

    if (br_take) begin
      if (slot_is_req && !((state_q == S_REQ) && sram.inst_addr_ok)) begin
        redir_valid_d = 1'b1;
        redir_addr_d  = br_addr;
      end else begin
        // req_pc is younger than the delay slot (or the slot is being accepted right now).
        req_pc_d      = br_addr;
        redir_valid_d = 1'b0;
      end

      if (kill) begin
        case (state_q)
          S_FULL: state_d = S_REQ;
          S_WAIT: begin
            if (sram.inst_data_ok) begin
              state_d  = S_REQ;
              cancel_d = 1'b0;
            end else begin
              cancel_d = 1'b1;
            end
          end
          S_REQ: if (sram.inst_addr_ok) cancel_d = 1'b1;
          default: ;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_REQ;
      req_pc_q      <= RESET_PC;
      // NOTE: datapath registers are reset as well so pc/inst/buffer read 0 out of reset.
      fly_pc_q      <= '0;
      buf_pc_q      <= '0;
      buf_inst_q    <= '0;
      cancel_q      <= 1'b0;
      redir_valid_q <= 1'b0;
      redir_addr_q  <= '0;
      out_valid_q   <= 1'b0;
      out_pc_q      <= '0;
      out_inst_q    <= '0;
    end else begin
      state_q       <= state_d;
      req_pc_q      <= req_pc_d;
      fly_pc_q      <= fly_pc_d;
      buf_pc_q      <= buf_pc_d;
      buf_inst_q    <= buf_inst_d;
      cancel_q      <= cancel_d;
      redir_valid_q <= redir_valid_d;
      redir_addr_q  <= redir_addr_d;
      out_valid_q   <= out_valid_d;
      out_pc_q      <= out_pc_d;
      out_inst_q    <= out_inst_d;
    end
  end

  assign sram.inst_req  = rst_n & (state_q == S_REQ);
  assign sram.inst_addr = rst_n ? req_pc_q : '0;
  assign if_to_id_bus   = {out_valid_q, out_pc_q};
  assign if_inst        = out_inst_q;
  assign stallreq       = ~out_valid_q & rst_n;

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios followed by random stall/branch/SRAM
// timing, checked against a program-order model of the delivered instruction stream.
module tb_if_fetch;
  localparam logic [31:0] RESET_PC     = 32'hBFC0_0000;
  localparam int          STARVE_LIMIT = 200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  stall;
  logic [32:0] br_bus;
  logic [32:0] if_to_id_bus;
  logic [31:0] if_inst;
  logic        stallreq;

  if_fetch_if sram ();

  if_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .br_bus       (br_bus),
    .sram         (sram),
    .if_to_id_bus (if_to_id_bus),
    .if_inst      (if_inst),
    .stallreq     (stallreq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // SRAM model: accepted addresses in order, with programmable extra latency.
  logic [31:0] aq[$];
  int          age;
  int          req_wait;
  int          aok_delay;
  int          dok_delay;
  logic        last_aok;

  // Stream model: next pc decode must receive, plus a pending target behind an undelivered delay slot.
  logic [31:0] e_pc;
  logic        pend_v;
  logic [31:0] pend_t;
  logic        prev_hold;
  logic [31:0] prev_addr;
  int          starve;
  int          delivered;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == RESET_PC) ? 32'h3C01_1234 : ((a * 32'h9E37_79B1) ^ 32'h0F1E_2D3C);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    aq.delete();
    age       = 0;
    req_wait  = 0;
    last_aok  = 1'b0;
    e_pc      = RESET_PC;
    pend_v    = 1'b0;
    pend_t    = '0;
    prev_hold = 1'b0;
    prev_addr = '0;
    starve    = 0;
  endtask

  task automatic step(input logic s1, input logic br, input logic [31:0] ba,
                      input logic aok_en, input logic dok_en);
    logic ce;
    logic take;
    logic dok;
    logic aok;
    int   outstanding;
    @(negedge clk);
    ce   = if_to_id_bus[32];
    take = br && !s1;
    check("stallreq", stallreq, !ce);
    if (!ce) check("idle_zero", {if_to_id_bus[31:0], if_inst}, 64'd0);
    if (prev_hold) check("addr_stable", {sram.inst_req, sram.inst_addr}, {1'b1, prev_addr});

    if (ce && !s1) begin
      check("pc", if_to_id_bus[31:0], e_pc);
      check("inst", if_inst, mem_word(e_pc));
      e_pc   = pend_v ? pend_t : e_pc + 32'd4;
      pend_v = 1'b0;
      if (take) e_pc = ba;
      starve = 0;
      delivered++;
    end else begin
      if (take) begin
        pend_v = 1'b1;
        pend_t = ba;
      end
      starve++;
    end

    stall  = {4'b0000, s1, 1'b0};
    br_bus = {br, ba};

    outstanding = aq.size();
    if (outstanding != 0) age++;
    dok = dok_en && (outstanding != 0) && (age >= 1 + dok_delay);
    sram.inst_data_ok = dok;
    sram.inst_rdata   = dok ? mem_word(aq[0]) : $urandom;
    if (dok) void'(aq.pop_front());

    aok = aok_en && sram.inst_req && (req_wait >= aok_delay);
    sram.inst_addr_ok = aok;
    if (aok) begin
      check("one_outstanding", outstanding, 0);
      aq.push_back(sram.inst_addr);
      age      = 0;
      req_wait = 0;
    end else if (sram.inst_req) begin
      req_wait++;
    end
    last_aok  = aok;
    prev_hold = sram.inst_req && !aok && !take;
    prev_addr = sram.inst_addr;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_req_addr", {sram.inst_req, sram.inst_addr}, 33'd0);
    check("rst_bus", if_to_id_bus, 33'd0);
    check("rst_inst", if_inst, 32'd0);
    check("rst_stallreq", stallreq, 1'b0);
    stall             = '0;
    br_bus            = '0;
    sram.inst_addr_ok = 1'b0;
    sram.inst_data_ok = 1'b0;
    sram.inst_rdata   = '0;
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic        s1;
    logic        br;
    logic [31:0] ba;
    logic        got;

    stall             = '0;
    br_bus            = '0;
    sram.inst_addr_ok = 1'b0;
    sram.inst_data_ok = 1'b0;
    sram.inst_rdata   = '0;
    aok_delay         = 0;
    dok_delay         = 0;
    delivered         = 0;
    model_clear();

    repeat (3) @(negedge clk);
    check("reset_req_addr", {sram.inst_req, sram.inst_addr}, 33'd0);
    check("reset_bus", if_to_id_bus, 33'd0);
    check("reset_stallreq", stallreq, 1'b0);
    rst_n = 1'b1;

    // First fetch with immediate SRAM.
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    check("first_addr", {sram.inst_req, sram.inst_addr}, {1'b1, RESET_PC});
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1, 1'b1);
    check("first_bus", if_to_id_bus, {1'b1, RESET_PC});
    check("first_inst", if_inst, 32'h3C01_1234);
    check("second_addr", {sram.inst_req, sram.inst_addr}, {1'b1, RESET_PC + 32'd4});

    // Decode stalled for 4 cycles: 0004 lands in the buffer, no new request.
    step(1'b1, 1'b0, '0, 1'b1, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1, 1'b1);
    check("stall_hold_pc", if_to_id_bus, {1'b1, RESET_PC});
    check("stall_no_req", sram.inst_req, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1, 1'b1);
    check("stall_hold_pc2", if_to_id_bus, {1'b1, RESET_PC});
    check("stall_no_req2", sram.inst_req, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);

    // Branch while 0008 sits in the output register and 000C is in flight.
    step(1'b1, 1'b0, '0, 1'b1, 1'b1);
    check("br_slot_pc", if_to_id_bus, {1'b1, RESET_PC + 32'd8});
    check("br_fly_addr", {sram.inst_req, sram.inst_addr}, {1'b1, RESET_PC + 32'd12});
    step(1'b0, 1'b1, RESET_PC + 32'h100, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    check("br_drop_idle", if_to_id_bus, 33'd0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    check("br_target_addr", {sram.inst_req, sram.inst_addr}, {1'b1, RESET_PC + 32'h100});
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    check("br_target_bus", if_to_id_bus, {1'b1, RESET_PC + 32'h100});

    // Slow SRAM: addr_ok after 3 waiting cycles, data_ok 2 cycles late.
    aok_delay = 3;
    dok_delay = 2;
    delivered = 0;
    repeat (40) step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    check("slow_progress", delivered >= 4, 1'b1);
    aok_delay = 0;
    dok_delay = 0;

    // Reset with a request outstanding.
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step(1'b0, 1'b0, '0, 1'b1, 1'b1);
      got = last_aok;
    end
    check("reach_wait", got, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("wait_no_req", sram.inst_req, 1'b0);
    do_reset();
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    check("post_rst_addr", {sram.inst_req, sram.inst_addr}, {1'b1, RESET_PC});
    repeat (6) step(1'b0, 1'b0, '0, 1'b1, 1'b1);

    // Random stall, branch and SRAM timing against the stream model.
    for (int i = 0; i < 3000; i++) begin
      s1 = ($urandom_range(0, 3) == 0);
      br = ($urandom_range(0, 5) == 0);
      ba = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      step(s1, br, ba, $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
      if (starve == STARVE_LIMIT) check("starve", starve, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
